branch_predictor: RTL

Fetch-side branch predictor that produces the `Predicted`/`PC_Pre` pair travelling down the pipeline and consumes the 2-bit resolution code produced in Execute to train itself. It is a direct-mapped branch target buffer with a 2-bit saturating direction counter per entry and registered lookup outputs aligned with the IF/ID register. It also keeps saturating correct/mispredict statistics.

---
 rtl/bp_pkg.sv | 33 +++
 rtl/bp_sat_counter.sv | 31 +++
 rtl/branch_predictor.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared constants, BTB entry layout and counter helpers for the branch predictor.
package bp_pkg;

  localparam int unsigned BP_WIDTH = 32;
  localparam int unsigned CTR_W    = 2;

  localparam logic [1:0] RES_WRONG_TARGET = 2'b00;
  localparam logic [1:0] RES_RIGHT        = 2'b01;
  localparam logic [1:0] RES_NOT_TAKEN    = 2'b10;
  localparam logic [1:0] RES_TAKEN        = 2'b11;

  localparam logic [CTR_W-1:0] CTR_SNT = 2'd0;
  localparam logic [CTR_W-1:0] CTR_WNT = 2'd1;
  localparam logic [CTR_W-1:0] CTR_WT  = 2'd2;
  localparam logic [CTR_W-1:0] CTR_ST  = 2'd3;

  // Tag is stored right-aligned and zero-extended to BP_WIDTH.
  typedef struct packed {
    logic                valid;
    logic [BP_WIDTH-1:0] tag;
    logic [BP_WIDTH-1:0] target;
    logic [CTR_W-1:0]    ctr;
  } bp_entry_t;

  function automatic logic [CTR_W-1:0] ctr_inc(input logic [CTR_W-1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] ctr_dec(input logic [CTR_W-1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - CTR_W'(1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Saturating up-counter; holds at all-ones.
module bp_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, registered fetch-side lookup
// and Execute-side training, plus correct/mispredict statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned WIDTH_DATA_LENGTH = 32,
  parameter int unsigned ENTRIES           = 16,
  parameter int unsigned INDEX_BITS        = $clog2(ENTRIES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_Fetch,
  input  logic                         Stall,
  input  logic                         Flush,
  output logic                         Predicted,
  output logic [WIDTH_DATA_LENGTH-1:0] PC_Pre,
  input  logic                         Upd_Valid,
  input  logic [WIDTH_DATA_LENGTH-1:0] Upd_PC,
  input  logic                         Upd_Taken,
  input  logic [WIDTH_DATA_LENGTH-1:0] Upd_Target,
  input  logic [1:0]                   Result,
  output logic [15:0]                  Correct_Count,
  output logic [15:0]                  Mispredict_Count
);

  localparam int unsigned W     = WIDTH_DATA_LENGTH;
  localparam int unsigned TAG_W = W - INDEX_BITS - 2;

  localparam bp_entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};

  bp_entry_t tbl_q [ENTRIES];
  bp_entry_t tbl_d [ENTRIES];

  logic         predicted_q, predicted_d;
  logic [W-1:0] pc_pre_q, pc_pre_d;

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]      f_tag, u_tag;
  bp_entry_t             f_ent, u_ent;
  logic                  f_hit, u_hit, f_taken;
  logic [W-1:0]          pc_seq;
  logic                  upd_pc_unused;

  assign f_idx = PC_Fetch[INDEX_BITS+1:2];
  assign f_tag = PC_Fetch[W-1:INDEX_BITS+2];
  assign u_idx = Upd_PC[INDEX_BITS+1:2];
  assign u_tag = Upd_PC[W-1:INDEX_BITS+2];
  assign upd_pc_unused = ^Upd_PC[1:0];

  // Lookup reads the pre-update table: no write-to-read bypass.
  assign f_ent   = tbl_q[f_idx];
  assign u_ent   = tbl_q[u_idx];
  assign f_hit   = f_ent.valid && (f_ent.tag == BP_WIDTH'(f_tag));
  assign u_hit   = u_ent.valid && (u_ent.tag == BP_WIDTH'(u_tag));
  assign f_taken = f_hit && f_ent.ctr[1];
  assign pc_seq  = PC_Fetch + W'(4);

  // Output register: Flush beats Stall beats a fresh lookup.
  always_comb begin
    predicted_d = predicted_q;
    pc_pre_d    = pc_pre_q;
    if (Flush) begin
      predicted_d = 1'b0;
      pc_pre_d    = '0;
    end else if (!Stall) begin
      predicted_d = f_taken;
      pc_pre_d    = f_taken ? W'(f_ent.target) : pc_seq;
    end
  end

  // Training: at most one entry is written per edge.
  always_comb begin
    tbl_d = tbl_q;
    if (Upd_Valid) begin
      case (Result)
        RES_TAKEN: begin
          tbl_d[u_idx].valid  = 1'b1;
          tbl_d[u_idx].tag    = BP_WIDTH'(u_tag);
          tbl_d[u_idx].target = BP_WIDTH'(Upd_Target);
          tbl_d[u_idx].ctr    = CTR_WT;
        end
        RES_WRONG_TARGET: begin
          tbl_d[u_idx].valid  = 1'b1;
          tbl_d[u_idx].tag    = BP_WIDTH'(u_tag);
          tbl_d[u_idx].target = BP_WIDTH'(Upd_Target);
          tbl_d[u_idx].ctr    = ctr_inc(u_ent.ctr);
        end
        RES_NOT_TAKEN: begin
          if (u_hit) begin
            tbl_d[u_idx].ctr = ctr_dec(u_ent.ctr);
          end
        end
        RES_RIGHT: begin
          if (u_hit) begin
            tbl_d[u_idx].ctr = Upd_Taken ? ctr_inc(u_ent.ctr) : ctr_dec(u_ent.ctr);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_q       <= '{default: ENTRY_RST};
      predicted_q <= 1'b0;
      pc_pre_q    <= '0;
    end else begin
      tbl_q       <= tbl_d;
      predicted_q <= predicted_d;
      pc_pre_q    <= pc_pre_d;
    end
  end

  assign Predicted = predicted_q;
  assign PC_Pre    = pc_pre_q;

  bp_sat_counter #(.WIDTH(16)) u_correct_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (Upd_Valid && (Result == RES_RIGHT)),
    .count (Correct_Count)
  );

  bp_sat_counter #(.WIDTH(16)) u_mispredict_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (Upd_Valid && (Result != RES_RIGHT)),
    .count (Mispredict_Count)
  );

endmodule
